mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM/IO port between the fetcher (32-bit instruction reads) and the LSB (1/2/4-byte loads and stores).

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//  Shared constants, state encoding and helpers for the memory arbiter that
//  multiplexes the byte-wide RAM/IO port between the fetcher and the LSB.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int          DATA_WIDTH            = 32;
    localparam logic [31:0] ZERO_DATA             = 32'h0000_0000;
    localparam logic        TRUE                  = 1'b1;
    localparam logic        FALSE                 = 1'b0;

    // Addresses at or above this value are memory-mapped I/O.
    localparam logic [31:0] IO_ADDR_BASE_DEFAULT  = 32'h0003_0000;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_FETCH = 2'd1,
        MEM_LOAD  = 2'd2,
        MEM_STORE = 2'd3
    } mem_state_e;

    // Number of byte beats for an LSB access; anything other than 1 or 2
    // is handled as a full word.
    function automatic logic [2:0] beat_count(input logic [2:0] size);
        case (size)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//  Shares the single byte-wide RAM/IO port between the instruction fetcher
//  (32-bit reads) and the LSB (1/2/4-byte loads and stores). Single-cycle
//  requests are latched, each access is serialised into byte beats, and the
//  assembled result is returned with a one-cycle done pulse.
//
// Ports
//  clk, rst            clock / synchronous active-high reset
//  rdy                 low freezes all state; mem_wr is forced low
//  in_fetcher_*        fetch request (pulse + word address)
//  out_fetcher_*       instruction valid pulse + little-endian instruction
//  in_lsb_*            LSB request (pulse, store flag, address, size, data)
//  out_lsb_*           load-data valid / store-complete pulse + load data
//  in_rob_misbranch    flush speculative fetch/load traffic
//  mem_din/dout/a/wr   byte-wide RAM/IO port
//  io_buffer_full      I/O sink cannot take a byte this cycle
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  MEM_IDLE  | no access in flight; picks LSB before fetch
//  MEM_FETCH | 4-byte instruction read, abortable by misbranch
//  MEM_LOAD  | 1/2/4-byte data read, abortable by misbranch
//  MEM_STORE | 1/2/4-byte write, committed (ignores misbranch)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_ADDR_BASE = IO_ADDR_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,

    input  logic                  in_fetcher_ce,
    input  logic [DATA_WIDTH-1:0] in_fetcher_addr,
    output logic                  out_fetcher_ce,
    output logic [DATA_WIDTH-1:0] out_fetcher_instr,

    input  logic                  in_lsb_ce,
    input  logic                  in_lsb_wr,
    input  logic [DATA_WIDTH-1:0] in_lsb_addr,
    input  logic [2:0]            in_lsb_size,
    input  logic [DATA_WIDTH-1:0] in_lsb_data,
    output logic                  out_lsb_ce,
    output logic [DATA_WIDTH-1:0] out_lsb_data,

    input  logic                  in_rob_misbranch,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    mem_state_e            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;

    logic                  fetch_pend_q, fetch_pend_d;
    logic [DATA_WIDTH-1:0] fetch_addr_q, fetch_addr_d;

    logic                  lsb_pend_q, lsb_pend_d;
    logic                  lsb_wr_q, lsb_wr_d;
    logic [DATA_WIDTH-1:0] lsb_addr_q, lsb_addr_d;
    logic [2:0]            lsb_size_q, lsb_size_d;
    logic [DATA_WIDTH-1:0] lsb_data_q, lsb_data_d;

    // Access currently being serialised.
    logic [DATA_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [2:0]            cur_len_q, cur_len_d;
    logic [DATA_WIDTH-1:0] cur_data_q, cur_data_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;

    logic                  fetch_ce_d, lsb_ce_d;
    logic [DATA_WIDTH-1:0] fetch_instr_d, lsb_rdata_d;

    logic [DATA_WIDTH-1:0] beat_addr;
    logic [1:0]            byte_idx;
    logic [DATA_WIDTH-1:0] capture;
    logic                  io_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= MEM_IDLE;
            cnt_q             <= 3'd0;
            fetch_pend_q      <= FALSE;
            fetch_addr_q      <= ZERO_DATA;
            lsb_pend_q        <= FALSE;
            lsb_wr_q          <= FALSE;
            lsb_addr_q        <= ZERO_DATA;
            lsb_size_q        <= 3'd0;
            lsb_data_q        <= ZERO_DATA;
            cur_addr_q        <= ZERO_DATA;
            cur_len_q         <= 3'd0;
            cur_data_q        <= ZERO_DATA;
            buf_q             <= ZERO_DATA;
            out_fetcher_ce    <= FALSE;
            out_fetcher_instr <= ZERO_DATA;
            out_lsb_ce        <= FALSE;
            out_lsb_data      <= ZERO_DATA;
        end else if (rdy) begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            fetch_pend_q      <= fetch_pend_d;
            fetch_addr_q      <= fetch_addr_d;
            lsb_pend_q        <= lsb_pend_d;
            lsb_wr_q          <= lsb_wr_d;
            lsb_addr_q        <= lsb_addr_d;
            lsb_size_q        <= lsb_size_d;
            lsb_data_q        <= lsb_data_d;
            cur_addr_q        <= cur_addr_d;
            cur_len_q         <= cur_len_d;
            cur_data_q        <= cur_data_d;
            buf_q             <= buf_d;
            out_fetcher_ce    <= fetch_ce_d;
            out_fetcher_instr <= fetch_instr_d;
            out_lsb_ce        <= lsb_ce_d;
            out_lsb_data      <= lsb_rdata_d;
        end
    end

    always_comb begin
        // cnt counts issued addresses; the byte returned for address cnt-1
        // is on mem_din this cycle.
        beat_addr = cur_addr_q + {29'd0, cnt_q};
        byte_idx  = cnt_q[1:0] - 2'd1;
        capture   = buf_q;
        capture[{byte_idx, 3'b000} +: 8] = mem_din;
        io_hold   = (beat_addr >= IO_ADDR_BASE) && io_buffer_full;

        state_d       = state_q;
        cnt_d         = cnt_q;
        fetch_pend_d  = fetch_pend_q;
        fetch_addr_d  = fetch_addr_q;
        lsb_pend_d    = lsb_pend_q;
        lsb_wr_d      = lsb_wr_q;
        lsb_addr_d    = lsb_addr_q;
        lsb_size_d    = lsb_size_q;
        lsb_data_d    = lsb_data_q;
        cur_addr_d    = cur_addr_q;
        cur_len_d     = cur_len_q;
        cur_data_d    = cur_data_q;
        buf_d         = buf_q;
        fetch_ce_d    = FALSE;
        lsb_ce_d      = FALSE;
        fetch_instr_d = out_fetcher_instr;
        lsb_rdata_d   = out_lsb_data;
        mem_a         = ZERO_DATA;
        mem_dout      = 8'h00;
        mem_wr        = FALSE;

        // Misbranch drops speculative requests; a pending store is committed.
        if (in_rob_misbranch) begin
            fetch_pend_d = FALSE;
            if (!lsb_wr_q) begin
                lsb_pend_d = FALSE;
            end
        end

        if (in_fetcher_ce && !in_rob_misbranch) begin
            fetch_pend_d = TRUE;
            fetch_addr_d = in_fetcher_addr;
        end

        if (in_lsb_ce && (in_lsb_wr || !in_rob_misbranch)) begin
            lsb_pend_d = TRUE;
            lsb_wr_d   = in_lsb_wr;
            lsb_addr_d = in_lsb_addr;
            lsb_size_d = in_lsb_size;
            lsb_data_d = in_lsb_data;
        end

        unique case (state_q)
            MEM_IDLE: begin
                // The _d copies include a request arriving this cycle.
                if (lsb_pend_d) begin
                    lsb_pend_d = FALSE;
                    cur_addr_d = lsb_addr_d;
                    cur_len_d  = beat_count(lsb_size_d);
                    cur_data_d = lsb_data_d;
                    buf_d      = ZERO_DATA;
                    cnt_d      = 3'd0;
                    state_d    = lsb_wr_d ? MEM_STORE : MEM_LOAD;
                end else if (fetch_pend_d) begin
                    fetch_pend_d = FALSE;
                    cur_addr_d   = fetch_addr_d;
                    cur_len_d    = 3'd4;
                    buf_d        = ZERO_DATA;
                    cnt_d        = 3'd0;
                    state_d      = MEM_FETCH;
                end
            end

            MEM_FETCH, MEM_LOAD: begin
                if (in_rob_misbranch) begin
                    state_d = MEM_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q < cur_len_q) begin
                        mem_a = beat_addr;
                    end
                    if (cnt_q != 3'd0) begin
                        buf_d = capture;
                    end
                    if (cnt_q == cur_len_q) begin
                        // buf was cleared at start, so short loads come out
                        // zero-extended.
                        if (state_q == MEM_FETCH) begin
                            fetch_instr_d = capture;
                            fetch_ce_d    = TRUE;
                        end else begin
                            lsb_rdata_d = capture;
                            lsb_ce_d    = TRUE;
                        end
                        state_d = MEM_IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            MEM_STORE: begin
                // A blocked I/O beat is simply not issued; cnt stays put.
                if (!io_hold) begin
                    mem_wr   = rdy;
                    mem_a    = beat_addr;
                    mem_dout = cur_data_q[{cnt_q[1:0], 3'b000} +: 8];
                    if (cnt_q == cur_len_q - 3'd1) begin
                        lsb_ce_d = TRUE;
                        state_d  = MEM_IDLE;
                        cnt_d    = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_fetcher_ce;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_ce;
    logic [31:0] out_fetcher_instr;
    logic        in_lsb_ce, in_lsb_wr;
    logic [31:0] in_lsb_addr;
    logic [2:0]  in_lsb_size;
    logic [31:0] in_lsb_data;
    logic        out_lsb_ce;
    logic [31:0] out_lsb_data;
    logic        in_rob_misbranch;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    always #5 clk = ~clk;

    mem_arbiter #(.IO_ADDR_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetcher_ce(in_fetcher_ce), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ce(out_fetcher_ce), .out_fetcher_instr(out_fetcher_instr),
        .in_lsb_ce(in_lsb_ce), .in_lsb_wr(in_lsb_wr), .in_lsb_addr(in_lsb_addr),
        .in_lsb_size(in_lsb_size), .in_lsb_data(in_lsb_data),
        .out_lsb_ce(out_lsb_ce), .out_lsb_data(out_lsb_data),
        .in_rob_misbranch(in_rob_misbranch),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fetch_done_n = 0, lsb_done_n = 0, wr_n = 0;
    int fetch_done_cyc = 0, lsb_done_cyc = 0;
    bit io_rand = 1'b0;

    typedef struct { bit st; logic [31:0] d; } lsb_exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

    logic [31:0] fq[$];
    lsb_exp_t    lq[$];
    wr_t         wq[$];
    lsb_exp_t    le;
    wr_t         we;

    // Byte-addressed memory model; unwritten bytes follow a fixed pattern.
    logic [7:0] ram [logic [31:0]];
    logic [31:0] a_prev = 32'h0;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic int model_beats(input logic [2:0] s);
        if (s == 3'd1) return 1;
        if (s == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r = 32'h0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ram_rd(a + 32'(k));
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // RAM answers one cycle after the address it saw.
    always @(negedge clk) begin
        mem_din = ram_rd(a_prev);
        a_prev  = mem_a;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            fq.delete(); lq.delete(); wq.delete();
        end else if (rdy) begin
            if (out_fetcher_ce) begin
                fetch_done_n++; fetch_done_cyc = cyc;
                check("fetch_expected", 32'(fq.size() != 0), 32'd1);
                if (fq.size() != 0) check("fetch_instr", out_fetcher_instr, fq.pop_front());
            end
            if (out_lsb_ce) begin
                lsb_done_n++; lsb_done_cyc = cyc;
                check("lsb_expected", 32'(lq.size() != 0), 32'd1);
                if (lq.size() != 0) begin
                    le = lq.pop_front();
                    if (le.st) check("store_writes_done", 32'(wq.size()), 32'd0);
                    else       check("load_data", out_lsb_data, le.d);
                end
            end
            if (mem_wr) begin
                wr_n++;
                check("write_while_io_full", 32'((mem_a >= IO_BASE) && io_buffer_full), 32'd0);
                check("write_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    we = wq.pop_front();
                    check("write_addr", mem_a, we.a);
                    check("write_data", 32'(mem_dout), 32'(we.d));
                end
            end
            if (in_rob_misbranch) begin
                fq.delete();
                for (int i = lq.size() - 1; i >= 0; i--) if (!lq[i].st) lq.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
        in_fetcher_ce = 1'b0; in_lsb_ce = 1'b0; in_rob_misbranch = 1'b0;
        if (io_rand) io_buffer_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drive_fetch(input logic [31:0] a);
        in_fetcher_ce = 1'b1; in_fetcher_addr = a;
        fq.push_back(model_read(a, 4));
    endtask

    task automatic drive_lsb(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int n;
        n = model_beats(s);
        in_lsb_ce = 1'b1; in_lsb_wr = wr; in_lsb_addr = a; in_lsb_size = s; in_lsb_data = d;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                wq.push_back('{a + 32'(k), d[8*k +: 8]});
                ram[a + 32'(k)] = d[8*k +: 8];
            end
            lq.push_back('{1'b1, 32'h0});
        end else begin
            lq.push_back('{1'b0, model_read(a, n)});
        end
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((fq.size() != 0 || lq.size() != 0 || wq.size() != 0) && t < budget) begin
            step(); t++;
        end
        check("idle_timeout", 32'(t >= budget), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, l0, w0, kind, pick;
        logic [31:0] a, d, a_frz;
        logic [2:0]  sz;

        rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
        in_fetcher_ce = 1'b0; in_fetcher_addr = 32'h0;
        in_lsb_ce = 1'b0; in_lsb_wr = 1'b0; in_lsb_addr = 32'h0;
        in_lsb_size = 3'd0; in_lsb_data = 32'h0; in_rob_misbranch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fetch_ce", 32'(out_fetcher_ce), 32'd0);
        check("rst_lsb_ce", 32'(out_lsb_ce), 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        rst = 1'b0;

        // 1: single fetch, address sequence and pulse timing
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
        ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        drive_fetch(32'h1000);
        step();
        for (int k = 0; k < 4; k++) begin
            check("t1_mem_a", mem_a, 32'h1000 + 32'(k));
            step();
        end
        check("t1_no_early_ce", 32'(out_fetcher_ce), 32'd0);
        check("t1_mem_a_idle", mem_a, 32'h0);
        step();
        check("t1_ce", 32'(out_fetcher_ce), 32'd1);
        check("t1_instr", out_fetcher_instr, 32'h0000_0513);
        wait_idle(50);

        // 2: simultaneous fetch and load, load first
        ram[32'h2002] = 8'hEF; ram[32'h2003] = 8'hBE;
        drive_fetch(32'h1000);
        drive_lsb(1'b0, 32'h2002, 3'd2, 32'h0);
        step();
        wait_idle(60);
        check("t2_order", 32'(lsb_done_cyc < fetch_done_cyc), 32'd1);
        check("t2_load", out_lsb_data, 32'h0000_BEEF);

        // 3: I/O store with back-pressure
        w0 = wr_n;
        drive_lsb(1'b1, IO_BASE, 3'd4, 32'hDEAD_BEEF);
        step();
        check("t3_beat0", 32'(mem_wr), 32'd1);
        step();
        io_buffer_full = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold", 32'(mem_wr), 32'd0);
            step();
        end
        io_buffer_full = 1'b0;
        wait_idle(40);
        check("t3_write_count", 32'(wr_n - w0), 32'd4);

        // 4: misbranch aborts a fetch, next fetch completes
        f0 = fetch_done_n;
        drive_fetch(32'h1100);
        step(); step(); step();
        in_rob_misbranch = 1'b1;
        step();
        check("t4_idle_mem_a", mem_a, 32'h0);
        repeat (8) step();
        check("t4_no_ce", 32'(fetch_done_n - f0), 32'd0);
        drive_fetch(32'h1200);
        step();
        wait_idle(50);
        check("t4_refetch", 32'(fetch_done_n - f0), 32'd1);

        // 5: misbranch does not disturb a store
        l0 = lsb_done_n; w0 = wr_n;
        drive_lsb(1'b1, 32'h1300, 3'd4, 32'hA1B2_C3D4);
        step(); step();
        in_rob_misbranch = 1'b1;
        step();
        wait_idle(40);
        check("t5_store_done", 32'(lsb_done_n - l0), 32'd1);
        check("t5_write_count", 32'(wr_n - w0), 32'd4);
        drive_lsb(1'b0, 32'h1300, 3'd4, 32'h0);
        step();
        wait_idle(40);

        // 6: rdy freeze mid-load, then reset with a fetch pending
        f0 = fetch_done_n; l0 = lsb_done_n;
        drive_lsb(1'b0, 32'h1040, 3'd4, 32'h0);
        step();
        drive_fetch(32'h1000);
        step();
        rdy = 1'b0;
        #1;
        a_frz = mem_a;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_frozen_a", mem_a, a_frz);
            check("t6_no_wr", 32'(mem_wr), 32'd0);
        end
        rst = 1'b1; rdy = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_fetch_ce", 32'(out_fetcher_ce), 32'd0);
        check("t6_rst_lsb_ce", 32'(out_lsb_ce), 32'd0);
        check("t6_rst_instr", out_fetcher_instr, 32'h0);
        check("t6_rst_ldata", out_lsb_data, 32'h0);
        check("t6_rst_mem_a", mem_a, 32'h0);
        check("t6_rst_dout", 32'(mem_dout), 32'd0);
        repeat (12) step();
        check("t6_no_fetch", 32'(fetch_done_n - f0), 32'd0);
        check("t6_no_load", 32'(lsb_done_n - l0), 32'd0);

        // Randomised traffic
        io_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            pick = $urandom_range(0, 4);
            a  = 32'h1000 + 32'($urandom_range(0, 255));
            d  = $urandom();
            sz = (pick == 0) ? 3'd1 : (pick == 1) ? 3'd2 : (pick == 2) ? 3'd4 :
                 (pick == 3) ? 3'd3 : 3'd7;
            case (kind)
                0: drive_fetch({a[31:2], 2'b00});
                1: drive_lsb(1'b0, a, sz, 32'h0);
                2: drive_lsb(1'b1, ($urandom_range(0, 1) == 1) ? IO_BASE + 32'($urandom_range(0, 255)) : a, sz, d);
                default: begin
                    drive_fetch({a[31:2], 2'b00});
                    drive_lsb(1'b0, a + 32'd64, sz, 32'h0);
                end
            endcase
            step();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 7)) step();
                in_rob_misbranch = 1'b1;
                step();
            end
            wait_idle(100);
        end
        io_rand = 1'b0;
        io_buffer_full = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
